can_reg_access_arbiter: RTL
===========================

Name: can_reg_access_arbiter

Overview:
- Sequences all accesses to the controller's bank of 8-bit write-enabled configuration/status registers.
- Shares the bank between two requesters:
  - host bus port: read/write.
  - internal update port: write-only, e.g. error-counter and status writeback.
- Generates one-hot per-register write strobes and a registered read-back path.
- Enforces reset-mode write protection on timing and acceptance registers.

Parameters:
- NUM_REGS, 32, number of 8-bit registers in the bank.
- ADDR_W, 5, address width; NUM_REGS <= 2**ADDR_W.
- LOCK_MASK, 32'h0000_00F0, bit i=1 means register i is writable only while reset_mode=1.
- MAX_INT_BURST, 4, consecutive internal grants allowed while a host request waits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- host_req  in  1  host access request; held until host_ack.
- host_we  in  1  1=write, 0=read.
- host_addr  in  ADDR_W  host register address.
- host_wdata  in  8  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  8  read data; valid while host_ack=1 and held until the next host read.
- int_req  in  1  internal write request; held until int_ack.
- int_addr  in  ADDR_W  internal register address.
- int_wdata  in  8  internal write data.
- int_ack  out  1  one-cycle completion pulse.
- reset_mode  in  1  controller reset-mode flag.
- reg_rdata_all  in  NUM_REGS*8  concatenated register outputs; register i occupies bits [8i+7:8i].
- reg_we  out  NUM_REGS  one-hot write strobes to the register bank.
- reg_wdata  out  8  shared write data to the register bank.
- lock_err  out  1  one-cycle pulse, coincident with ack, when a write was blocked by lock.

Behaviour:
- FSM states: IDLE, ACCESS, ACK. Reset state is IDLE.
- Reset values: host_ack=0, int_ack=0, host_rdata=8'h00, reg_we=0, reg_wdata=8'h00, lock_err=0, starvation counter=0, grant=none.
- IDLE, no request: stay in IDLE.
- IDLE, request(s) present: choose the winner and latch addr, we (forced 1 for internal), wdata, grant owner and the lock verdict; go to ACCESS.
- Arbitration:
  - internal wins if both request, unless starve_cnt == MAX_INT_BURST, in which case host wins.
  - starve_cnt increments on each internal grant made while host_req=1, saturating at MAX_INT_BURST.
  - starve_cnt clears on a host grant, or in any IDLE cycle with host_req=0.
- ACCESS lasts exactly 1 cycle:
  - for writes, reg_we[addr]=1 and reg_wdata=latched data, unless blocked.
  - for reads, host_rdata <= reg_rdata_all[addr] at the end of the cycle.
  - go to ACK.
- ACK lasts 1 cycle: the owner's ack=1 and lock_err as computed; go to IDLE.
- Latency: request first seen in IDLE at cycle 0 → reg_we in cycle 1 → ack in cycle 2. Minimum period between grants is 3 cycles.
- A request still high in the IDLE cycle after ack is treated as a new request. Requesters drop req in the cycle after ack to avoid repeats.
- Blocked write: write with LOCK_MASK[addr]=1 and reset_mode=0 as sampled at grant.
  - no reg_we.
  - ack still issued.
  - lock_err=1 in the ACK cycle.
- A reset_mode change after grant does not affect the access in flight.
- Address >= NUM_REGS: write produces no strobe; read returns 8'h00; ack issued; lock_err=0.
- reg_we is never multi-hot and is only nonzero in ACCESS.
- rst_n asserted mid-access: immediate return to IDLE with all outputs at reset values. The in-flight access is dropped with no ack; the requester retries because req is still high.
- req dropped before ack: the access still completes and the ack pulse is still issued.

Optional Feature:
- CAN_REG_LOCK_EN defined: reset-mode lock enforced as described above.
- CAN_REG_LOCK_EN undefined: LOCK_MASK ignored, all in-range writes strobe, lock_err tied 0, and reset_mode is unused.

Test Plan:
- Host write addr=3 data=8'hA5, reset_mode=0 → reg_we=32'h8 in cycle 1, reg_wdata=8'hA5, host_ack in cycle 2, lock_err=0.
- Host read addr=2 with reg_rdata_all byte 2 = 8'h5C → host_rdata=8'h5C with host_ack in cycle 2; out-of-range addr=31 with NUM_REGS=20 → 8'h00.
- Host write addr=5 (locked) with reset_mode=0 → no reg_we, host_ack=1 and lock_err=1 together. Repeat with reset_mode=1 → reg_we[5]=1, lock_err=0. With CAN_REG_LOCK_EN undefined, both cases strobe.
- host_req and int_req held continuously → exactly 4 internal grants, then 1 host grant, repeating; same-cycle requests → internal first.
- int_req for addr=7 with rst_n pulsed low during ACCESS → reg_we=0 and int_ack=0 immediately. After release, a re-grant occurs and int_ack arrives 2 cycles after the first IDLE cycle.
- Random host/internal traffic over 10k cycles → reg_we always one-hot-or-zero, no ack without a prior grant, and every held request acked within 15 cycles.

Source files
------------

// File: rtl/can_reg_access_arbiter.sv
// can_reg_access_arbiter: shares the 8-bit register bank between the host bus
// (read/write) and the internal update port (write-only).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host_req/we/addr/wdata -> host_ack, host_rdata   host access port
//   int_req/addr/wdata  -> int_ack                   internal write port
//   reset_mode          controller reset-mode flag (lock qualifier)
//   reg_rdata_all       concatenated bank outputs, reg i at [8i+7:8i]
//   reg_we, reg_wdata   one-hot write strobes and shared write data
//   lock_err            pulse with ack when a write was blocked by lock
//
// Optional: define CAN_REG_LOCK_EN to enforce the reset-mode write lock on
// registers flagged in LOCK_MASK. Without it every in-range write strobes.
//
// Each grant runs IDLE -> ACCESS -> ACK, so grants are at least 3 cycles
// apart. Internal wins ties until MAX_INT_BURST internal grants have been
// made while the host waited; the next grant then goes to the host.

module can_reg_access_arbiter #(
    parameter int                  NUM_REGS      = 32,
    parameter int                  ADDR_W        = 5,
    parameter logic [NUM_REGS-1:0] LOCK_MASK     = 'h0000_00F0,
    parameter int                  MAX_INT_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_ack,
    output logic [7:0]            host_rdata,
    input  logic                  int_req,
    input  logic [ADDR_W-1:0]     int_addr,
    input  logic [7:0]            int_wdata,
    output logic                  int_ack,
    input  logic                  reset_mode,
    input  logic [NUM_REGS*8-1:0] reg_rdata_all,
    output logic [NUM_REGS-1:0]   reg_we,
    output logic [7:0]            reg_wdata,
    output logic                  lock_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam int               CNT_W   = $clog2(MAX_INT_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INT_BURST);

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              lat_host;
    logic              lat_we;
    logic              lat_blocked;
    logic [ADDR_W-1:0] lat_addr;

    logic              pick_int;
    logic              pick_host;
    logic              sel_we;
    logic              sel_blocked;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    logic [NUM_REGS-1:0] sel_onehot;
    logic [7:0]        rd_byte;

    // Winner selection; host only overrides once the burst budget is used
    always_comb begin
        pick_int  = int_req && !(host_req && starve_cnt == CNT_MAX);
        pick_host = host_req && !pick_int;
        sel_addr  = pick_int ? int_addr : host_addr;
        sel_we    = pick_int ? 1'b1 : host_we;
        sel_wdata = pick_int ? int_wdata : host_wdata;
    end

    // Out-of-range addresses match no register, giving a zero strobe
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_onehot[i] = (sel_addr == ADDR_W'(i));
        end
    end

    // Read mux; out-of-range addresses return zero
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (lat_addr == ADDR_W'(i)) begin
                rd_byte = reg_rdata_all[i*8 +: 8];
            end
        end
    end

`ifdef CAN_REG_LOCK_EN
    // Verdict taken at grant so later reset_mode changes cannot affect it
    assign sel_blocked = sel_we && (|(sel_onehot & LOCK_MASK)) && !reset_mode;
`else
    logic unused_lock;
    assign unused_lock = ^{reset_mode, LOCK_MASK};
    assign sel_blocked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            lat_host    <= 1'b0;
            lat_we      <= 1'b0;
            lat_blocked <= 1'b0;
            lat_addr    <= '0;
            host_ack    <= 1'b0;
            int_ack     <= 1'b0;
            host_rdata  <= 8'h00;
            reg_we      <= '0;
            reg_wdata   <= 8'h00;
            lock_err    <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            int_ack  <= 1'b0;
            lock_err <= 1'b0;
            reg_we   <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_host || !host_req) begin
                        starve_cnt <= '0;
                    end else if (pick_int && starve_cnt != CNT_MAX) begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                    if (pick_int || pick_host) begin
                        lat_host    <= pick_host;
                        lat_we      <= sel_we;
                        lat_addr    <= sel_addr;
                        lat_blocked <= sel_blocked;
                        if (sel_we) begin
                            reg_wdata <= sel_wdata;
                        end
                        // Strobe is registered here so it is live in ACCESS
                        if (sel_we && !sel_blocked) begin
                            reg_we <= sel_onehot;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        host_rdata <= rd_byte;
                    end
                    host_ack <= lat_host;
                    int_ack  <= !lat_host;
                    lock_err <= lat_blocked;
                    state    <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
